// File: rtl/clb_cfg_pkg.sv
// clb_cfg_pkg: shared definitions for the clb39 serial configuration loader.
//   - clb_frame_t : packed layout of one 37-bit CLB configuration frame (bit 0 = mem[0])
//   - FRAME_W     : frame width, derived from the layout
//   - PREAMBLE    : 4-bit stream preamble
//   - cfg_state_e : loader FSM states
// No ports (package).
package clb_cfg_pkg;

  // Field order is MSB first, so mem lands in [15:0] and floporlatch in [36].
  typedef struct packed {
    logic       floporlatch;  // [36]
    logic       dqmux2;       // [35]
    logic       dqmux1;       // [34]
    logic       o2m3_1;       // [33]
    logic       o2m2_1;       // [32]
    logic       o2m1_1;       // [31]
    logic       o2m3_0;       // [30]
    logic       o2m2_0;       // [29]
    logic       o2m1_0;       // [28]
    logic [1:0] mux6;         // [27:26]
    logic [1:0] mux5;         // [25:24]
    logic [1:0] mux4;         // [23:22]
    logic [1:0] mux3;         // [21:20]
    logic [1:0] mux2;         // [19:18]
    logic [1:0] comb;         // [17:16]
    logic [15:0] mem;         // [15:0]
  } clb_frame_t;

  localparam int unsigned FRAME_W  = $bits(clb_frame_t);
  localparam int unsigned LEN_W    = 16;
  localparam int unsigned CRC_W    = 8;
  localparam int unsigned CNT_W    = 6;
  localparam logic [3:0]  PREAMBLE = 4'b0010;
  localparam logic [7:0]  CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    StIdle, StLen, StFstart, StFdata, StFstop, StCrc, StDone, StErr
  } cfg_state_e;

endpackage

// File: rtl/clb_cfg_crc8.sv
// clb_cfg_crc8: bit-serial CRC-8 (poly 0x07, init 0x00), MSB-first shift register.
// Ports:
//   i_clk  clock (posedge)
//   i_rst  synchronous active-high reset, clears the CRC
//   i_clr  synchronous clear
//   i_en   advance the CRC by one bit
//   i_bit  data bit
//   o_crc  current CRC value
module clb_cfg_crc8
  import clb_cfg_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb = r_crc[CRC_W-1] ^ i_bit;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: serial configuration writer for the clb39 array.
// Stream: idle 1s, preamble 0010, 16-bit length N (MSB first), then N frames of
// {start 0, FRAME_W data bits LSB first, stop 1}. Each good frame produces one cfg_we pulse.
// Optional feature macro CFG_CRC_EN: a CRC-8 byte (MSB first) over all frame data bits follows
// the last frame and must match before cfg_done is raised.
// Ports:
//   K        clock (posedge)
//   RST      synchronous active-high reset
//   din      serial data bit, sampled only when din_vld=1
//   din_vld  data-valid qualifier
//   cfg_we   one-cycle write strobe to the CLB array
//   cfg_addr target CLB index, valid with cfg_we, holds last value
//   cfg_data frame contents, valid with cfg_we, holds last value
//   busy     high from preamble match until DONE/ERR
//   cfg_done configuration complete, sticky
//   cfg_err  framing/length/CRC error, sticky
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int unsigned NUM_CLB = 64,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic               K,
  input  logic               RST,
  input  logic               din,
  input  logic               din_vld,
  output logic               cfg_we,
  output logic [ADDR_W-1:0]  cfg_addr,
  output logic [FRAME_W-1:0] cfg_data,
  output logic               busy,
  output logic               cfg_done,
  output logic               cfg_err
);

  localparam int unsigned       IDX_W     = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  MaxLen    = LEN_W'(NUM_CLB);
  localparam logic [CNT_W-1:0]  LenLast   = CNT_W'(LEN_W - 1);
  localparam logic [CNT_W-1:0]  FrameLast = CNT_W'(FRAME_W - 1);

  cfg_state_e         r_state;
  logic [3:0]         r_hist;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [IDX_W-1:0]   r_idx;
  logic [FRAME_W-1:0] r_frame;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [FRAME_W-1:0] r_data;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [3:0]         w_hist_nxt;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [IDX_W-1:0]   w_idx_inc;
  logic               w_last_frame;

  assign w_hist_nxt   = {r_hist[2:0], din};
  assign w_len_nxt    = {r_len[LEN_W-2:0], din};
  assign w_idx_inc    = r_idx + 1'b1;
  // Full 16-bit compare so a wide N can never alias onto the small index counter.
  assign w_last_frame = ({{(LEN_W - IDX_W){1'b0}}, w_idx_inc} == r_len);

`ifdef CFG_CRC_EN
  localparam logic [CNT_W-1:0] CrcLast = CNT_W'(CRC_W - 1);

  logic [CRC_W-2:0] r_crc_rx;
  logic [CRC_W-1:0] w_crc;
  logic             w_crc_en;
  logic             w_crc_clr;

  // Only frame payload bits feed the CRC; start/stop bits are excluded.
  assign w_crc_en  = din_vld && (r_state == StFdata);
  assign w_crc_clr = (r_state == StIdle);

  clb_cfg_crc8 u_crc (
    .i_clk (K),
    .i_rst (RST),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (din),
    .o_crc (w_crc)
  );
`endif

  always_ff @(posedge K) begin
    if (RST) begin
      r_state  <= StIdle;
      r_hist   <= '1;
      r_len    <= '0;
      r_bitcnt <= '0;
      r_idx    <= '0;
      r_frame  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef CFG_CRC_EN
      r_crc_rx <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      // Raised one cycle after entering DONE, i.e. one cycle after the last write strobe.
      if (r_state == StDone) r_done <= 1'b1;
      if (din_vld) begin
        unique case (r_state)
          StIdle: begin
            r_hist <= w_hist_nxt;
            if (w_hist_nxt == PREAMBLE) begin
              r_state  <= StLen;
              r_busy   <= 1'b1;
              r_bitcnt <= '0;
            end
          end
          StLen: begin
            r_len    <= w_len_nxt;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == LenLast) begin
              r_bitcnt <= '0;
              r_idx    <= '0;
              if (w_len_nxt == '0) begin
                r_state <= StDone;
                r_busy  <= 1'b0;
              end else if (w_len_nxt > MaxLen) begin
                r_state <= StErr;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
              end else begin
                r_state <= StFstart;
              end
            end
          end
          StFstart: begin
            if (din) begin
              r_state <= StErr;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state  <= StFdata;
              r_bitcnt <= '0;
            end
          end
          StFdata: begin
            // LSB first: the first received bit ends up in bit 0.
            r_frame  <= {din, r_frame[FRAME_W-1:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == FrameLast) r_state <= StFstop;
          end
          StFstop: begin
            if (!din) begin
              r_state <= StErr;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_we   <= 1'b1;
              r_addr <= r_idx[ADDR_W-1:0];
              r_data <= r_frame;
              r_idx  <= w_idx_inc;
              if (w_last_frame) begin
`ifdef CFG_CRC_EN
                r_state  <= StCrc;
                r_bitcnt <= '0;
`else
                r_state <= StDone;
                r_busy  <= 1'b0;
`endif
              end else begin
                r_state <= StFstart;
              end
            end
          end
`ifdef CFG_CRC_EN
          StCrc: begin
            r_crc_rx <= {r_crc_rx[CRC_W-3:0], din};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == CrcLast) begin
              r_busy <= 1'b0;
              if ({r_crc_rx, din} == w_crc) begin
                r_state <= StDone;
              end else begin
                r_state <= StErr;
                r_err   <= 1'b1;
              end
            end
          end
`endif
          default: ;  // DONE and ERR absorb all input until reset
        endcase
      end
    end
  end

  assign cfg_we   = r_we;
  assign cfg_addr = r_addr;
  assign cfg_data = r_data;
  assign busy     = r_busy;
  assign cfg_done = r_done;
  assign cfg_err  = r_err;

endmodule

// File: tb/tb_clb_cfg_loader.sv
module tb_clb_cfg_loader;
  import clb_cfg_pkg::*;

  localparam int unsigned NUM_CLB = 64;
  localparam int unsigned ADDR_W  = 6;
  // clb39 default: mem=16'h0116, mux2/3/4=2'b10, o2m1_1/o2m2_1/o2m3_1=1
  localparam logic [FRAME_W-1:0] DEF_FRAME = 37'h3_80A8_0116;

  logic               K = 1'b0;
  logic               RST = 1'b1;
  logic               din = 1'b1;
  logic               din_vld = 1'b0;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [FRAME_W-1:0] cfg_data;
  logic               busy;
  logic               cfg_done;
  logic               cfg_err;

  always #5 K = ~K;

  clb_cfg_loader #(
    .NUM_CLB (NUM_CLB),
    .ADDR_W  (ADDR_W)
  ) dut (
    .K        (K),
    .RST      (RST),
    .din      (din),
    .din_vld  (din_vld),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge K) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge.
  logic               mon_clr = 1'b1;
  int                 wr_cnt, dbl_cnt, we_cyc, done_cyc;
  logic               prev_we;
  logic [ADDR_W-1:0]  wr_addr [128];
  logic [FRAME_W-1:0] wr_data [128];

  always @(negedge K) begin
    if (mon_clr) begin
      wr_cnt = 0; dbl_cnt = 0; we_cyc = -1; done_cyc = -1; prev_we = 1'b0;
    end else begin
      if (cfg_we) begin
        if (prev_we) dbl_cnt++;
        if (wr_cnt < 128) begin
          wr_addr[wr_cnt] = cfg_addr;
          wr_data[wr_cnt] = cfg_data;
        end
        wr_cnt++;
        we_cyc = cyc;
      end
      if (cfg_done && done_cyc < 0) done_cyc = cyc;
      prev_we = cfg_we;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic       gaps = 1'b0;
  logic [7:0] tb_crc;

  task automatic send_bit(input logic b);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        din = 1'($urandom); din_vld = 1'b0;
        @(posedge K); #1;
      end
    end
    din = b; din_vld = 1'b1;
    @(posedge K); #1;
    din_vld = 1'b0; din = 1'b1;
  endtask

  task automatic do_reset();
    RST = 1'b1; din_vld = 1'b0; din = 1'b1; mon_clr = 1'b1;
    repeat (2) @(posedge K);
    #1 RST = 1'b0; mon_clr = 1'b0;
  endtask

  function automatic logic [FRAME_W-1:0] frame_val(input logic [FRAME_W-1:0] base, input int i);
    return base ^ (FRAME_W'(i) << 29) ^ FRAME_W'(i * 3);
  endfunction

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  task automatic send_preamble_len(input int n_len);
    logic [15:0] l;
    l = 16'(n_len);
    repeat (3) send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check("busy after preamble", 64'(busy), 64'd1);
    for (int b = 15; b >= 0; b--) send_bit(l[b]);
  endtask

  task automatic send_frames(input int n_send, input logic [FRAME_W-1:0] base,
                             input int bad_start, input int bad_stop);
    logic [FRAME_W-1:0] fr;
    for (int f = 0; f < n_send; f++) begin
      fr = frame_val(base, f);
      send_bit(f == bad_start);
      for (int b = 0; b < FRAME_W; b++) begin
        send_bit(fr[b]);
        tb_crc = crc_step(tb_crc, fr[b]);
      end
      send_bit(f != bad_stop);
    end
  endtask

  task automatic send_crc(input logic flip);
    logic [7:0] tx;
    tx = tb_crc ^ (flip ? 8'h10 : 8'h00);
    for (int b = 7; b >= 0; b--) send_bit(tx[b]);
  endtask

  // A complete legal N=1 stream; must be ignored once in DONE/ERR.
  task automatic send_trailer();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    for (int b = 15; b >= 0; b--) send_bit(b == 0);
    send_bit(1'b0);
    for (int b = 0; b < FRAME_W; b++) send_bit(1'($urandom));
    send_bit(1'b1);
  endtask

  typedef struct {
    string              name;
    int                 n_len;
    int                 n_send;
    logic [FRAME_W-1:0] base;
    int                 bad_start;
    int                 bad_stop;
    logic               gaps;
    logic               crc_flip;
    int                 exp_wr;
    logic               exp_done;
    logic               exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    do_reset();
    gaps = v.gaps;
    tb_crc = 8'h00;
    send_preamble_len(v.n_len);
    if (v.n_len > int'(NUM_CLB)) check({v.name, " err after len"}, 64'(cfg_err), 64'd1);
    send_frames(v.n_send, v.base, v.bad_start, v.bad_stop);
`ifdef CFG_CRC_EN
    if (v.n_len > 0 && v.n_len <= int'(NUM_CLB) && v.bad_start < 0 && v.bad_stop < 0)
      send_crc(v.crc_flip);
`endif
    send_trailer();
    gaps = 1'b0;
    repeat (3) @(negedge K);
    #1;
    check({v.name, " writes"}, 64'(wr_cnt), 64'(v.exp_wr));
    check({v.name, " single-cycle we"}, 64'(dbl_cnt), 64'd0);
    for (int i = 0; i < v.exp_wr && i < wr_cnt && i < 128; i++) begin
      check($sformatf("%s addr[%0d]", v.name, i), 64'(wr_addr[i]), 64'(i));
      check($sformatf("%s data[%0d]", v.name, i), 64'(wr_data[i]), 64'(frame_val(v.base, i)));
    end
    check({v.name, " done"}, 64'(cfg_done), 64'(v.exp_done));
    check({v.name, " err"}, 64'(cfg_err), 64'(v.exp_err));
    check({v.name, " busy"}, 64'(busy), 64'd0);
    if (v.exp_wr > 0) begin
      check({v.name, " addr hold"}, 64'(cfg_addr), 64'(v.exp_wr - 1));
      check({v.name, " data hold"}, 64'(cfg_data), 64'(frame_val(v.base, v.exp_wr - 1)));
    end
`ifndef CFG_CRC_EN
    if (v.exp_done && v.exp_wr > 0)
      check({v.name, " done after last we"}, 64'(done_cyc), 64'(we_cyc + 1));
`endif
  endtask

  initial begin
    vecs.push_back('{"default",   1,  1, DEF_FRAME,       -1, -1, 1'b0, 1'b0,  1, 1'b1, 1'b0});
    vecs.push_back('{"three_gap", 3,  3, 37'h1_2345_6789, -1, -1, 1'b1, 1'b0,  3, 1'b1, 1'b0});
    vecs.push_back('{"stop_bad1", 2,  2, 37'h0_F0F0_1234, -1,  1, 1'b0, 1'b0,  1, 1'b0, 1'b1});
    vecs.push_back('{"stop_bad0", 1,  1, 37'h1_0000_0001, -1,  0, 1'b0, 1'b0,  0, 1'b0, 1'b1});
    vecs.push_back('{"start_bad", 2,  2, 37'h0_5555_AAAA,  0, -1, 1'b0, 1'b0,  0, 1'b0, 1'b1});
    vecs.push_back('{"len65",    65,  0, DEF_FRAME,       -1, -1, 1'b0, 1'b0,  0, 1'b0, 1'b1});
    vecs.push_back('{"len257",  257,  0, DEF_FRAME,       -1, -1, 1'b0, 1'b0,  0, 1'b0, 1'b1});
    vecs.push_back('{"len0",      0,  0, DEF_FRAME,       -1, -1, 1'b0, 1'b0,  0, 1'b1, 1'b0});
    vecs.push_back('{"max64",    64, 64, 37'h0_A5A5_F00F, -1, -1, 1'b0, 1'b0, 64, 1'b1, 1'b0});
`ifdef CFG_CRC_EN
    vecs.push_back('{"crc_flip",  2,  2, 37'h1_CAFE_0042, -1, -1, 1'b0, 1'b1,  2, 1'b0, 1'b1});
`endif

    // Reset state
    do_reset();
    check("reset cfg_we", 64'(cfg_we), 64'd0);
    check("reset cfg_addr", 64'(cfg_addr), 64'd0);
    check("reset cfg_data", 64'(cfg_data), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset cfg_done", 64'(cfg_done), 64'd0);
    check("reset cfg_err", 64'(cfg_err), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // RST in the middle of frame 0 payload, then a clean N=1 stream.
    do_reset();
    tb_crc = 8'h00;
    send_preamble_len(1);
    send_bit(1'b0);
    for (int b = 0; b < 10; b++) send_bit(DEF_FRAME[b]);
    RST = 1'b1;
    @(posedge K); #1;
    RST = 1'b0;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst err", 64'(cfg_err), 64'd0);
    check("midrst no write", 64'(wr_cnt), 64'd0);
    tb_crc = 8'h00;
    send_preamble_len(1);
    send_frames(1, DEF_FRAME, -1, -1);
`ifdef CFG_CRC_EN
    send_crc(1'b0);
`endif
    repeat (3) @(negedge K);
    #1;
    check("midrst writes", 64'(wr_cnt), 64'd1);
    check("midrst addr", 64'(wr_addr[0]), 64'd0);
    check("midrst data", 64'(wr_data[0]), 64'(DEF_FRAME));
    check("midrst done", 64'(cfg_done), 64'd1);
    check("midrst err end", 64'(cfg_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
